// File: rtl/vend_credit_controller_if.sv
// Signal bundle between the coin/keypad front end, the dispenser/changer
// actuators and the vending credit controller.
interface vend_credit_controller_if #(
  parameter int CREDIT_W = 5
);
  // Handshakes: vend_req/coin_out_req are raised by the controller and held
  // until the matching ack is sampled high on a rising clk edge; each sampled
  // coin_out_ack returns exactly one nickel. Coin/select/cancel inputs are
  // single-cycle pulses with no back-pressure; refusal is signalled by
  // coin_reject.
  logic                nickel;
  logic                dime;
  logic                quarter;
  logic                select;
  logic                cancel;
  logic                vend_req;
  logic                vend_ack;
  logic                coin_out_req;
  logic                coin_out_ack;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                busy;
  logic                fault;

  modport master (
    output nickel, dime, quarter, select, cancel, vend_ack, coin_out_ack,
    input  vend_req, coin_out_req, credit, coin_reject, busy, fault
  );

  modport slave (
    input  nickel, dime, quarter, select, cancel, vend_ack, coin_out_ack,
    output vend_req, coin_out_req, credit, coin_reject, busy, fault
  );
endinterface

// File: rtl/vend_credit_controller.sv
// Vending transaction sequencer: accumulates nickel-unit credit, vends one
// priced item over a req/ack handshake, then pays out the remainder in nickels.
module vend_credit_controller #(
  parameter int CREDIT_W     = 5,
  parameter int PRICE_N      = 3,
  parameter int MAX_CREDIT_N = 20,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  vend_credit_controller_if.slave   bus,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CREDIT = 3'd1,
    S_VEND   = 3'd2,
    S_CHANGE = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int SUM_W = CREDIT_W + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                vend_req_q, vend_req_d;
  logic                coin_out_req_q, coin_out_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;

  logic [1:0]          coin_cnt;
  logic [2:0]          coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_any;
  logic                coin_fits;
  logic                timed_out;

  always_comb begin
    coin_cnt  = {1'b0, bus.nickel} + {1'b0, bus.dime} + {1'b0, bus.quarter};
    coin_any  = bus.nickel | bus.dime | bus.quarter;
    coin_val  = bus.nickel ? 3'd1 : (bus.dime ? 3'd2 : (bus.quarter ? 3'd5 : 3'd0));
    coin_sum  = SUM_W'(credit_q) + SUM_W'(coin_val);
    coin_fits = (coin_cnt == 2'd1) && (coin_sum <= SUM_W'(MAX_CREDIT_N));
    timed_out = (timer_q == TMR_W'(ACK_TIMEOUT - 1));
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    timer_d       = '0;
    // Every coin is refused unless the single accepted-coin path below claims it.
    coin_reject_d = coin_any;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (bus.cancel && (credit_q != '0)) begin
          state_d = S_CHANGE;
        end else if (bus.select && !bus.cancel) begin
          if (credit_q >= CREDIT_W'(PRICE_N)) state_d = S_VEND;
        end else if (!bus.select && !bus.cancel && coin_fits) begin
          credit_d      = coin_sum[CREDIT_W-1:0];
          coin_reject_d = 1'b0;
          state_d       = S_CREDIT;
        end
      end
      S_VEND: begin
        if (bus.vend_ack) begin
          credit_d = credit_q - CREDIT_W'(PRICE_N);
          state_d  = (credit_q != CREDIT_W'(PRICE_N)) ? S_CHANGE : S_IDLE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CHANGE: begin
        if (bus.coin_out_ack) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1)) state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    vend_req_d     = (state_d == S_VEND);
    coin_out_req_d = (state_d == S_CHANGE);
    fault_d        = (state_d == S_FAULT);
    busy_d         = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      vend_req_q     <= 1'b0;
      coin_out_req_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      vend_req_q     <= vend_req_d;
      coin_out_req_q <= coin_out_req_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
      fault_q        <= fault_d;
    end
  end

  assign bus.vend_req     = vend_req_q;
  assign bus.coin_out_req = coin_out_req_q;
  assign bus.credit       = credit_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign state_o          = state_q;

endmodule
